// File: rtl/ncl4_sync_sink.sv
// ncl4_sync_sink: clocked consumer for a four-rail (1-of-4) NCL wavefront source.
// Synchronises the rails, qualifies settled DATA/NULL wavefronts, drives the
// upstream completion signal and queues each legal DATA value in a small FIFO.
module ncl4_sync_sink #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int SEQ_CHECK     = 1,
  parameter int SEQ_STEP      = 3
) (
  input  logic        clk,
  input  logic        init,
  input  logic [3:0]  rails,
  output logic        comp_out,
  output logic [1:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        seq_err,
  output logic        illegal_err,
  output logic [15:0] wave_cnt
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [1:0]    STEP     = 2'(SEQ_STEP);

  typedef enum logic {WAIT_DATA = 1'b0, WAIT_NULL = 1'b1} state_t;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [1:0] rail_index(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  logic [3:0]    sync_q [SYNC_STAGES];
  logic [3:0]    s;
  logic [3:0]    prev_q;
  logic [SW-1:0] stab_q, stab_d;
  logic          settled;

  state_t        state_q;
  logic [1:0]    hist_q;
  logic          hist_vld_q;

  logic [1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          full, push, pop;
  logic [1:0]    push_val;

  assign s = sync_q[SYNC_STAGES-1];

  // Rail synchroniser chain plus the previous-sample register for stability.
  always_ff @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b0000;
      prev_q <= 4'b0000;
      stab_q <= '0;
    end else begin
      sync_q[0] <= rails;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= s;
      stab_q <= stab_d;
    end
  end

  // Stability count for this cycle's sample; settled is judged on the new count
  // so acceptance lands on the edge that completes the qualification window.
  always_comb begin
    stab_d = stab_q;
    if (s != prev_q)             stab_d = SW'(1);
    else if (stab_q != STAB_MAX) stab_d = stab_q + SW'(1);
    settled  = (stab_d == STAB_MAX);
    full     = (cnt_q == CNT_FULL);
    pop      = dout_valid && dout_ready;
    push_val = rail_index(s);
    push     = (state_q == WAIT_DATA) && settled && is_onehot(s) && !full;
  end

  // Handshake FSM with registered completion, error pulses, counter and history.
  always_ff @(posedge clk) begin
    if (init) begin
      state_q     <= WAIT_DATA;
      comp_out    <= 1'b0;
      seq_err     <= 1'b0;
      illegal_err <= 1'b0;
      wave_cnt    <= 16'd0;
      hist_q      <= 2'd0;
      hist_vld_q  <= 1'b0;
    end else begin
      seq_err     <= 1'b0;
      illegal_err <= 1'b0;
      case (state_q)
        WAIT_DATA: begin
          if (push) begin
            wave_cnt   <= wave_cnt + 16'd1;
            comp_out   <= 1'b1;
            state_q    <= WAIT_NULL;
            hist_q     <= push_val;
            hist_vld_q <= 1'b1;
            if ((SEQ_CHECK != 0) && hist_vld_q && (push_val != 2'(hist_q + STEP)))
              seq_err <= 1'b1;
          end else if (settled && (s != 4'b0000) && !is_onehot(s)) begin
            // Multi-hot is flagged but still completed so the ring keeps cycling.
            illegal_err <= 1'b1;
            comp_out    <= 1'b1;
            state_q     <= WAIT_NULL;
          end
        end
        WAIT_NULL: begin
          if (settled && (s == 4'b0000)) begin
            comp_out <= 1'b0;
            state_q  <= WAIT_DATA;
          end
        end
        default: begin
          comp_out <= 1'b0;
          state_q  <= WAIT_DATA;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; full uses the start-of-cycle count.
  always_ff @(posedge clk) begin
    if (init) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful under the occupancy count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_val;
  end

  // Head presentation, forced to zero while empty.
  always_comb begin
    dout_valid = (cnt_q != '0);
    dout       = dout_valid ? mem_q[rd_ptr_q] : 2'd0;
  end

endmodule

// File: tb/tb_ncl4_sync_sink.sv
// Directed testbench for ncl4_sync_sink with default parameters.
module tb_ncl4_sync_sink;

  logic        clk = 1'b0;
  logic        init;
  logic [3:0]  rails;
  logic        comp_out;
  logic [1:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        seq_err;
  logic        illegal_err;
  logic [15:0] wave_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int         n_seq = 0;
  int         n_ill = 0;
  logic [1:0] popq [$];

  ncl4_sync_sink dut (
    .clk         (clk),
    .init        (init),
    .rails       (rails),
    .comp_out    (comp_out),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .seq_err     (seq_err),
    .illegal_err (illegal_err),
    .wave_cnt    (wave_cnt)
  );

  always #5 clk = ~clk;

  // Event monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (seq_err)                 n_seq = n_seq + 1;
    if (illegal_err)             n_ill = n_ill + 1;
    if (dout_valid && dout_ready) popq.push_back(dout);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic hold(input logic [3:0] r, input int n);
    rails = r;
    cyc(n);
  endtask

  task automatic test_reset;
    init = 1'b1; rails = 4'b0000; dout_ready = 1'b1;
    cyc(3);
    init = 1'b0;
    cyc(1);
    n_cmp++; if (comp_out !== 1'b0)     begin n_bad++; $display("FAIL reset_comp got %b want 0", comp_out); end
    n_cmp++; if (dout_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_valid got %b want 0", dout_valid); end
    n_cmp++; if (dout !== 2'd0)         begin n_bad++; $display("FAIL reset_dout got %0d want 0", dout); end
    n_cmp++; if (seq_err !== 1'b0)      begin n_bad++; $display("FAIL reset_seq got %b want 0", seq_err); end
    n_cmp++; if (illegal_err !== 1'b0)  begin n_bad++; $display("FAIL reset_ill got %b want 0", illegal_err); end
    n_cmp++; if (wave_cnt !== 16'd0)    begin n_bad++; $display("FAIL reset_cnt got %0d want 0", wave_cnt); end
  endtask

  task automatic test_basic_seq;
    int seq0 = n_seq;
    int pbase = popq.size();
    rails = 4'b0001;
    cyc(3);
    n_cmp++; if (comp_out !== 1'b0)   begin n_bad++; $display("FAIL lat_early_comp got %b want 0", comp_out); end
    cyc(1);
    n_cmp++; if (comp_out !== 1'b1)   begin n_bad++; $display("FAIL lat_comp got %b want 1", comp_out); end
    n_cmp++; if (dout_valid !== 1'b1) begin n_bad++; $display("FAIL lat_valid got %b want 1", dout_valid); end
    cyc(6);
    hold(4'b0000, 10);
    n_cmp++; if (comp_out !== 1'b0)   begin n_bad++; $display("FAIL basic_null1 got %b want 0", comp_out); end
    hold(4'b1000, 10);
    n_cmp++; if (comp_out !== 1'b1)   begin n_bad++; $display("FAIL basic_data2 got %b want 1", comp_out); end
    hold(4'b0000, 10);
    n_cmp++; if (comp_out !== 1'b0)   begin n_bad++; $display("FAIL basic_null2 got %b want 0", comp_out); end
    hold(4'b0100, 10);
    n_cmp++; if (comp_out !== 1'b1)   begin n_bad++; $display("FAIL basic_data3 got %b want 1", comp_out); end
    hold(4'b0000, 10);
    n_cmp++; if (wave_cnt !== 16'd3)  begin n_bad++; $display("FAIL basic_cnt got %0d want 3", wave_cnt); end
    n_cmp++; if (n_seq - seq0 !== 0)  begin n_bad++; $display("FAIL basic_seq got %0d want 0", n_seq - seq0); end
    n_cmp++; if (popq.size() - pbase !== 3) begin n_bad++; $display("FAIL basic_npop got %0d want 3", popq.size() - pbase); end
    else begin
      n_cmp++; if (popq[pbase]   !== 2'd0) begin n_bad++; $display("FAIL basic_v0 got %0d want 0", popq[pbase]); end
      n_cmp++; if (popq[pbase+1] !== 2'd3) begin n_bad++; $display("FAIL basic_v1 got %0d want 3", popq[pbase+1]); end
      n_cmp++; if (popq[pbase+2] !== 2'd2) begin n_bad++; $display("FAIL basic_v2 got %0d want 2", popq[pbase+2]); end
    end
  endtask

  task automatic test_glitch;
    hold(4'b0010, 1);
    hold(4'b0000, 10);
    n_cmp++; if (comp_out !== 1'b0)   begin n_bad++; $display("FAIL glitch_comp got %b want 0", comp_out); end
    n_cmp++; if (wave_cnt !== 16'd3)  begin n_bad++; $display("FAIL glitch_cnt got %0d want 3", wave_cnt); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL glitch_valid got %b want 0", dout_valid); end
  endtask

  task automatic test_illegal;
    int ill0 = n_ill;
    hold(4'b0110, 10);
    n_cmp++; if (n_ill - ill0 !== 1)  begin n_bad++; $display("FAIL ill_pulses got %0d want 1", n_ill - ill0); end
    n_cmp++; if (comp_out !== 1'b1)   begin n_bad++; $display("FAIL ill_comp got %b want 1", comp_out); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL ill_valid got %b want 0", dout_valid); end
    n_cmp++; if (wave_cnt !== 16'd3)  begin n_bad++; $display("FAIL ill_cnt got %0d want 3", wave_cnt); end
    hold(4'b0000, 10);
    n_cmp++; if (comp_out !== 1'b0)   begin n_bad++; $display("FAIL ill_null got %b want 0", comp_out); end
  endtask

  task automatic test_backpressure;
    logic [1:0] vals [5] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd1};
    int seq0 = n_seq;
    int pbase = popq.size();
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hold(4'b0001 << vals[i], 10);
      n_cmp++; if (comp_out !== 1'b1) begin n_bad++; $display("FAIL bp_acc%0d got %b want 1", i, comp_out); end
      hold(4'b0000, 10);
    end
    hold(4'b0001 << vals[4], 10);
    n_cmp++; if (comp_out !== 1'b0)   begin n_bad++; $display("FAIL bp_full_comp got %b want 0", comp_out); end
    n_cmp++; if (wave_cnt !== 16'd7)  begin n_bad++; $display("FAIL bp_full_cnt got %0d want 7", wave_cnt); end
    n_cmp++; if (dout !== 2'd1)       begin n_bad++; $display("FAIL bp_head got %0d want 1", dout); end
    dout_ready = 1'b1;
    cyc(1);
    dout_ready = 1'b0;
    n_cmp++; if (comp_out !== 1'b0)   begin n_bad++; $display("FAIL bp_pop_comp got %b want 0", comp_out); end
    cyc(1);
    n_cmp++; if (comp_out !== 1'b1)   begin n_bad++; $display("FAIL bp_late_comp got %b want 1", comp_out); end
    n_cmp++; if (wave_cnt !== 16'd8)  begin n_bad++; $display("FAIL bp_late_cnt got %0d want 8", wave_cnt); end
    n_cmp++; if (dout_valid !== 1'b1) begin n_bad++; $display("FAIL bp_late_valid got %b want 1", dout_valid); end
    n_cmp++; if (dout !== 2'd0)       begin n_bad++; $display("FAIL bp_late_head got %0d want 0", dout); end
    dout_ready = 1'b1;
    hold(4'b0000, 10);
    n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain got %b want 0", dout_valid); end
    n_cmp++; if (n_seq - seq0 !== 0)  begin n_bad++; $display("FAIL bp_seq got %0d want 0", n_seq - seq0); end
    n_cmp++; if (popq.size() - pbase !== 5) begin n_bad++; $display("FAIL bp_npop got %0d want 5", popq.size() - pbase); end
    else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++; if (popq[pbase+i] !== vals[i]) begin n_bad++; $display("FAIL bp_v%0d got %0d want %0d", i, popq[pbase+i], vals[i]); end
      end
    end
  endtask

  task automatic test_seq_err;
    int seq0;
    int pbase;
    init = 1'b1; rails = 4'b0000; dout_ready = 1'b1;
    cyc(1);
    init = 1'b0;
    cyc(2);
    seq0 = n_seq;
    pbase = popq.size();
    hold(4'b0100, 10);
    hold(4'b0000, 10);
    n_cmp++; if (n_seq - seq0 !== 0)  begin n_bad++; $display("FAIL seq_first got %0d want 0", n_seq - seq0); end
    hold(4'b0001, 4);
    n_cmp++; if (seq_err !== 1'b1)    begin n_bad++; $display("FAIL seq_pulse got %b want 1", seq_err); end
    cyc(1);
    n_cmp++; if (seq_err !== 1'b0)    begin n_bad++; $display("FAIL seq_pulse_end got %b want 0", seq_err); end
    cyc(5);
    hold(4'b0000, 10);
    hold(4'b1000, 10);
    hold(4'b0000, 10);
    n_cmp++; if (n_seq - seq0 !== 1)  begin n_bad++; $display("FAIL seq_total got %0d want 1", n_seq - seq0); end
    n_cmp++; if (wave_cnt !== 16'd3)  begin n_bad++; $display("FAIL seq_cnt got %0d want 3", wave_cnt); end
    n_cmp++; if (popq.size() - pbase !== 3) begin n_bad++; $display("FAIL seq_npop got %0d want 3", popq.size() - pbase); end
    else begin
      n_cmp++; if (popq[pbase+1] !== 2'd0) begin n_bad++; $display("FAIL seq_queued got %0d want 0", popq[pbase+1]); end
    end
  endtask

  task automatic test_reset_mid;
    hold(4'b0001, 10);
    n_cmp++; if (comp_out !== 1'b1)   begin n_bad++; $display("FAIL mid_pre_comp got %b want 1", comp_out); end
    init = 1'b1;
    cyc(1);
    init = 1'b0;
    n_cmp++; if (comp_out !== 1'b0)   begin n_bad++; $display("FAIL mid_comp got %b want 0", comp_out); end
    n_cmp++; if (wave_cnt !== 16'd0)  begin n_bad++; $display("FAIL mid_cnt got %0d want 0", wave_cnt); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got %b want 0", dout_valid); end
    cyc(3);
    n_cmp++; if (comp_out !== 1'b0)   begin n_bad++; $display("FAIL mid_early got %b want 0", comp_out); end
    cyc(1);
    n_cmp++; if (comp_out !== 1'b1)   begin n_bad++; $display("FAIL mid_reacc got %b want 1", comp_out); end
    n_cmp++; if (wave_cnt !== 16'd1)  begin n_bad++; $display("FAIL mid_recnt got %0d want 1", wave_cnt); end
    n_cmp++; if (dout_valid !== 1'b1) begin n_bad++; $display("FAIL mid_revalid got %b want 1", dout_valid); end
    n_cmp++; if (dout !== 2'd0)       begin n_bad++; $display("FAIL mid_redout got %0d want 0", dout); end
    hold(4'b0000, 10);
  endtask

  initial begin
    init = 1'b1;
    rails = 4'b0000;
    dout_ready = 1'b1;
    test_reset;
    test_basic_seq;
    test_glitch;
    test_illegal;
    test_backpressure;
    test_seq_err;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
